alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 19 +
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU front end: op encodings,
// the legal-op test, the controller state type and the default ALU latency.
package alu_pkg;

    localparam int ALU_LAT_DEFAULT = 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last time.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters: arbitrates, drives the ALU,
// waits out its latency and returns a one-cycle response pulse to the owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    output state_t      dbg_state
);

    // Handshake: a request is accepted on a rising edge where req_valid[i] and
    // req_ready[i] are both high. req_ready is combinational from req_valid so
    // a requester may withdraw before acceptance; responses are never stalled.

    localparam logic [1:0] LAT_LAST = (ALU_LAT > 0) ? 2'(ALU_LAT - 1) : 2'd0;

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic        rearm_q;
    logic [1:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  op_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_result_q;
    logic [2:0]  rsp_flags_q;
    logic        rsp_err_q;

    logic [1:0]  gnt;
    logic [1:0]  hs;
    logic        sel;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_op;
    logic        sample_now;
    logic [1:0]  owner_onehot;

    rr_arbiter2 u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    // The IDLE cycle right after a response pulse does not grant, so a busy
    // pair of requesters sees one op every ALU_LAT+4 cycles.
    assign req_ready = (state_q == IDLE && !rearm_q && !reset) ? gnt : 2'b00;
    assign hs        = req_valid & req_ready;

    assign sel    = gnt[1];
    assign sel_a  = sel ? req_a[63:32] : req_a[31:0];
    assign sel_b  = sel ? req_b[63:32] : req_b[31:0];
    assign sel_op = sel ? req_op[7:4]  : req_op[3:0];

    assign sample_now   = (state_q == ISSUE && ALU_LAT == 0) ||
                          (state_q == WAIT && cnt_q == LAT_LAST);
    assign owner_onehot = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            rearm_q      <= 1'b0;
            cnt_q        <= 2'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 4'd0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 3'b000;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 3'b000;
            rsp_err_q    <= 1'b0;
            rearm_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (hs != 2'b00) begin
                        last_q  <= sel;
                        owner_q <= sel;
                        if (is_legal_op(sel_op)) begin
                            a_q     <= sel_a;
                            b_q     <= sel_b;
                            op_q    <= sel_op;
                            state_q <= ISSUE;
                        end else begin
                            // Rejected ops bypass the ALU and leave its inputs alone.
                            rsp_valid_q <= hs;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= 2'd0;
                    state_q <= (ALU_LAT == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    if (!sample_now) begin
                        cnt_q <= cnt_q + 2'd1;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    rearm_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (sample_now) begin
                rsp_valid_q  <= owner_onehot;
                rsp_result_q <= alu_result;
                rsp_flags_q  <= {alu_zero, alu_overflow, alu_carry};
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a clocked one-cycle ALU behind it: directed
// scenarios followed by randomized traffic from both requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int LAT = 1;
  localparam int EW  = 70;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_q = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_op;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err, alu_zero, alu_overflow, alu_carry;
  logic [3:0]  alu_op;
  state_t      dbg_state;

  logic        dv[2];
  logic [31:0] da[2];
  logic [31:0] db[2];
  logic [3:0]  dop[2];

  assign req_valid = {dv[1], dv[0]};
  assign req_a     = {da[1], da[0]};
  assign req_b     = {db[1], db[0]};
  assign req_op    = {dop[1], dop[0]};

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic          last_m;
  int            next_ok;
  logic [31:0]   m_a, m_b;
  logic [3:0]    m_op;
  logic [1:0]    last_own;
  logic [31:0]   last_res;
  logic [2:0]    last_fl;
  logic          last_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .dbg_state    (dbg_state)
  );

  // ALU arithmetic from signed/unsigned integer math: {result, zero, overflow, carry}
  function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic ovf, cy;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; ovf = 1'b0; cy = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        s = sa + sb;
        r = 32'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cy = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
      end
      OP_SUB: begin
        s = sa - sb;
        r = 32'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cy = (a >= b);
      end
      OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      OP_NOR: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), ovf, cy};
  endfunction

  // the shared clocked ALU, one cycle of latency
  always @(posedge clk) begin
    {alu_result, alu_zero, alu_overflow, alu_carry} <= ref_alu(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input int due, input logic [1:0] own, input logic err,
                                             input logic [2:0] fl, input logic [31:0] r);
    return {32'(due), own, err, fl, r};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [1:0]    hs, exp_ready;
    logic [EW-1:0] e;
    logic [34:0]   res;
    logic [3:0]    op;
    logic [31:0]   a, b;
    logic          g;
    int            due;

    if (reset) chk("ready_in_reset", req_ready, 2'b00);

    if (rst_q) begin
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_flags", rsp_flags, 3'b000);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", alu_op, 4'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      exp_q.delete();
      last_m = 1'b1;
      next_ok = cyc;
      m_a = 32'd0; m_b = 32'd0; m_op = 4'd0;
    end

    if (!reset) begin
      // ready: one-hot round-robin grant, only once the previous op is fully done
      if (req_valid == 2'b11)      g = last_m ? 1'b0 : 1'b1;
      else                         g = req_valid[1];
      exp_ready = (req_valid != 2'b00 && cyc >= next_ok) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, exp_ready);

      chk("alu_a_hold", alu_a, m_a);
      chk("alu_b_hold", alu_b, m_b);
      chk("alu_op_hold", alu_op, m_op);

      if (exp_q.size() > 0 && int'(exp_q[0][69:38]) < cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", 0, 1);
      end

      if (rsp_valid != 2'b00) begin
        last_own = rsp_valid; last_res = rsp_result; last_fl = rsp_flags; last_err = rsp_err;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e[69:38]);
          chk("rsp_owner", rsp_valid, e[37:36]);
          chk("rsp_err", rsp_err, e[35]);
          chk("rsp_flags", rsp_flags, e[34:32]);
          chk("rsp_result", rsp_result, e[31:0]);
        end
      end else begin
        chk("rsp_idle_zero", {rsp_result, rsp_flags, rsp_err}, 36'd0);
      end

      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        chk("hs_onehot", $countones(hs), 1);
        g = hs[1];
        op = req_op[4*g +: 4];
        a = req_a[32*g +: 32];
        b = req_b[32*g +: 32];
        last_m = g;
        if (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR}) begin
          res = ref_alu(op, a, b);
          due = cyc + LAT + 2;
          exp_q.push_back(pack_exp(due, hs, 1'b0, res[2:0], res[34:3]));
          m_a = a; m_b = b; m_op = op;
        end else begin
          due = cyc + 1;
          exp_q.push_back(pack_exp(due, hs, 1'b1, 3'b000, 32'd0));
        end
        // the cycle after a response is quiet, then the next grant may come
        next_ok = due + 2;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int limit, input bit must);
    bit got;
    got = 1'b0;
    da[i] = a; db[i] = b; dop[i] = op; dv[i] = 1'b1;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
      @(posedge clk); #1;
    end
    dv[i] = 1'b0;
    if (must) chk("hs_timeout", got, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic chk_last(input string name, input logic [1:0] own, input logic [31:0] r,
                          input logic [2:0] fl, input logic err);
    chk({name, "_owner"}, last_own, own);
    chk({name, "_result"}, last_res, r);
    chk({name, "_flags"}, last_fl, fl);
    chk({name, "_err"}, last_err, err);
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] op;
    case ($urandom_range(0, 5))
      0: op = OP_AND;
      1: op = OP_OR;
      2: op = OP_ADD;
      3: op = OP_SUB;
      4: op = OP_SLT;
      default: op = OP_NOR;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 3));
      1: case ($urandom_range(0, 2))
           0: v = 32'h7FFF_FFFF;
           1: v = 32'h8000_0000;
           default: v = 32'hFFFF_FFFF;
         endcase
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic rand_driver(input int i, input int n_ops);
    int gap;
    logic [3:0] op;
    for (int n = 0; n < n_ops; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : pick_op();
      issue(i, op, rand_operand(), rand_operand(), $urandom_range(2, 12), 1'b0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, actual cycles=%0d required<20000", cyc);
    $fatal(1, "bench stopped by watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; da[i] = 32'd0; db[i] = 32'd0; dop[i] = 4'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // lone ADD
    issue(0, OP_ADD, 32'd3, 32'd2, 8, 1'b1);
    drain();
    chk_last("add_3_2", 2'b01, 32'd5, 3'b000, 1'b0);

    // simultaneous requests right after reset: requester 0 first
    pulse_reset();
    fork
      issue(0, OP_SUB, 32'd3, 32'd3, 16, 1'b1);
      issue(1, OP_OR, 32'd3, 32'd2, 16, 1'b1);
    join
    drain();
    chk_last("or_3_2", 2'b10, 32'd3, 3'b000, 1'b0);

    // both requesters continuously busy: alternating grants
    fork
      begin
        issue(0, OP_ADD, 32'd10, 32'd20, 16, 1'b1);
        issue(0, OP_SUB, 32'd9, 32'd4, 16, 1'b1);
      end
      begin
        issue(1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 16, 1'b1);
        issue(1, OP_NOR, 32'h1234_5678, 32'h0, 16, 1'b1);
      end
    join
    drain();

    // illegal op from requester 1
    issue(1, 4'b1111, $urandom, $urandom, 8, 1'b1);
    drain();
    chk_last("illegal_op", 2'b10, 32'd0, 3'b000, 1'b1);

    // arithmetic corners
    issue(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 8, 1'b1);
    drain();
    chk_last("add_ovf", 2'b01, 32'h8000_0000, 3'b010, 1'b0);
    issue(0, OP_SLT, 32'd2, 32'd3, 8, 1'b1);
    drain();
    chk_last("slt_2_3", 2'b01, 32'd1, 3'b000, 1'b0);
    issue(0, OP_NOR, 32'd0, 32'd0, 8, 1'b1);
    drain();
    chk_last("nor_0_0", 2'b01, 32'hFFFF_FFFF, 3'b000, 1'b0);

    // reset while the op waits on the ALU: it never responds
    issue(0, OP_ADD, 32'd5, 32'd6, 8, 1'b1);
    @(posedge clk); #1;
    chk("in_wait", 64'(dbg_state), 64'(WAIT));
    pulse_reset();
    issue(0, OP_ADD, 32'd1, 32'd1, 1, 1'b1);
    drain();
    chk_last("after_reset", 2'b01, 32'd2, 3'b000, 1'b0);

    // randomized traffic from both requesters
    fork
      rand_driver(0, 40);
      rand_driver(1, 40);
    join
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
